// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchroniser, stability counter,
// debounced level and registered rise/fall/any_change strobes.
module input_debouncer #(
  parameter int               WIDTH           = 5,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0][CW-1:0]          cnt_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d;
  logic [WIDTH-1:0]                  level_d;
  logic [WIDTH-1:0]                  rise_d;
  logic [WIDTH-1:0]                  fall_d;
  logic                              any_d;

  // Plain flop chain; stage 0 is the only one that sees raw_in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = '0;
    level_d = level;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != level[i]) begin
        if (cnt_q[i] == LAST) begin
          level_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      level      <= RESET_VALUE;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level      <= level_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= any_d;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: two debouncer configurations checked every cycle
// against a sliding-window model, plus directed literal scenarios.
module tb_input_debouncer;

  localparam int W   = 5;
  localparam int SY0 = 2;
  localparam int DB0 = 16;
  localparam int SY1 = 3;
  localparam int DB1 = 1;
  localparam logic [W-1:0] RV0 = 5'b00000;
  localparam logic [W-1:0] RV1 = 5'b01101;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] raw_in  = '0;
  logic [W-1:0] lvl0, rise0, fall0;
  logic [W-1:0] lvl1, rise1, fall1;
  logic         any0, any1;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;
  int rise_cnt [W];
  int fall_cnt [W];
  int base_r   [W];
  int base_f   [W];

  input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(SY0),
    .DEBOUNCE_CYCLES(DB0), .RESET_VALUE(RV0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_in),
    .level(lvl0), .rise(rise0), .fall(fall0),
    .any_change(any0)
  );

  input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(SY1),
    .DEBOUNCE_CYCLES(DB1), .RESET_VALUE(RV1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_in),
    .level(lvl1), .rise(rise1), .fall(fall1),
    .any_change(any1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_no++;

  initial begin
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (rise0[i]) rise_cnt[i]++;
      if (fall0[i]) fall_cnt[i]++;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: raw history since reset release, one entry per edge.
  logic [W-1:0] rhist [$];
  logic [W-1:0] m_level [2];
  logic [W-1:0] m_rise  [2];
  logic [W-1:0] m_fall  [2];
  logic         m_any   [2];

  function automatic int sy(int k);
    return (k == 0) ? SY0 : SY1;
  endfunction

  function automatic int db(int k);
    return (k == 0) ? DB0 : DB1;
  endfunction

  function automatic logic [W-1:0] rv(int k);
    return (k == 0) ? RV0 : RV1;
  endfunction

  // Synchronised value seen at edge m (0 = first edge after release).
  function automatic logic s_at(int k, int m, int i);
    logic [W-1:0] v;
    if (m >= sy(k)) v = rhist[m - sy(k)];
    else v = rv(k);
    return v[i];
  endfunction

  // A channel flips once the last DB synchronised samples all differ.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rhist.delete();
      for (int k = 0; k < 2; k++) begin
        m_level[k] = rv(k);
        m_rise[k]  = '0;
        m_fall[k]  = '0;
        m_any[k]   = 1'b0;
      end
    end else begin
      int n;
      logic ok;
      logic [W-1:0] nl, r, f;
      n = rhist.size();
      for (int k = 0; k < 2; k++) begin
        nl = m_level[k];
        r  = '0;
        f  = '0;
        for (int i = 0; i < W; i++) begin
          ok = 1'b1;
          for (int j = 0; j < db(k); j++) begin
            if (n - j < 0) ok = 1'b0;
            else if (s_at(k, n - j, i) == m_level[k][i]) ok = 1'b0;
          end
          if (ok) begin
            nl[i] = ~m_level[k][i];
            r[i]  = nl[i];
            f[i]  = ~nl[i];
          end
        end
        m_level[k] = nl;
        m_rise[k]  = r;
        m_fall[k]  = f;
        m_any[k]   = |(r | f);
      end
      rhist.push_back(raw_in);
    end
  end

  always @(negedge clock) begin
    check("m0_level", lvl0, m_level[0]);
    check("m0_rise",  rise0, m_rise[0]);
    check("m0_fall",  fall0, m_fall[0]);
    check("m0_any",   any0, m_any[0]);
    check("m1_level", lvl1, m_level[1]);
    check("m1_rise",  rise1, m_rise[1]);
    check("m1_fall",  fall1, m_fall[1]);
    check("m1_any",   any1, m_any[1]);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < W; i++) begin
      base_r[i] = rise_cnt[i];
      base_f[i] = fall_cnt[i];
    end
  endtask

  // Edges from the first sampling edge (e_start+1) to the level change.
  task automatic wait_lvl(int ch, logic v, int e_start, string nm);
    int lat;
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      #1;
      if (lvl0[ch] == v) begin
        lat = edge_no - (e_start + 1);
        break;
      end
    end
    check(nm, lat, 17);
  endtask

  initial begin
    int e0;
    int p;
    logic [W-1:0] msk;

    raw_in = 5'b10101;
    #1 reset_n = 1'b0;
    #1;
    check("rst_level0", lvl0, 5'b00000);
    check("rst_rise0", rise0, 5'b00000);
    check("rst_fall0", fall0, 5'b00000);
    check("rst_any0", any0, 1'b0);
    check("rst_level1", lvl1, 5'b01101);
    hold(2);

    reset_n = 1'b1;
    e0 = edge_no;
    snap();
    wait_lvl(0, 1'b1, e0, "rel_latency");
    check("rel_level", lvl0, 5'b10101);
    check("rel_rise", rise0, 5'b10101);
    check("rel_fall", fall0, 5'b00000);
    check("rel_any", any0, 1'b1);
    hold(3);
    check("rel_rise_cnt4", rise_cnt[4] - base_r[4], 1);

    raw_in = 5'b00000;
    hold(20);
    snap();
    raw_in[0] = 1'b1;
    e0 = edge_no;
    wait_lvl(0, 1'b1, e0, "press_latency");
    check("press_rise", rise0, 5'b00001);
    check("press_level", lvl0, 5'b00001);
    hold(20);
    check("press_rise_cnt", rise_cnt[0] - base_r[0], 1);

    snap();
    for (int c = 0; c < 20; c++) begin
      raw_in[1] = ((c / 3) % 2) == 0;
      if (c == 18) e0 = edge_no;
      tick();
    end
    wait_lvl(1, 1'b1, e0, "bounce_latency");
    hold(20);
    check("bounce_rise_cnt", rise_cnt[1] - base_r[1], 1);
    check("bounce_fall_cnt", fall_cnt[1] - base_f[1], 0);

    raw_in[2] = 1'b1;
    hold(20);
    check("glitch_pre", lvl0[2], 1'b1);
    snap();
    raw_in[2] = 1'b0;
    hold(15);
    raw_in[2] = 1'b1;
    hold(25);
    check("glitch_level", lvl0[2], 1'b1);
    check("glitch_fall_cnt", fall_cnt[2] - base_f[2], 0);

    raw_in[4] = 1'b1;
    hold(20);
    check("simul_pre", lvl0[4], 1'b1);
    raw_in[3] = 1'b1;
    raw_in[4] = 1'b0;
    e0 = edge_no;
    wait_lvl(3, 1'b1, e0, "simul_latency");
    check("simul_rise", rise0, 5'b01000);
    check("simul_fall", fall0, 5'b10000);
    check("simul_any", any0, 1'b1);
    check("simul_lvl4", lvl0[4], 1'b0);
    @(posedge clock);
    #1;
    check("simul_any_after", any0, 1'b0);
    tick();

    raw_in[0] = 1'b0;
    hold(20);
    snap();
    raw_in[0] = 1'b1;
    hold(12);
    reset_n = 1'b0;
    #1;
    check("midrst_level", lvl0, 5'b00000);
    hold(3);
    check("midrst_no_strobe", rise_cnt[0] - base_r[0], 0);
    reset_n = 1'b1;
    e0 = edge_no;
    wait_lvl(0, 1'b1, e0, "midrst_latency");
    hold(20);
    check("midrst_rise_cnt", rise_cnt[0] - base_r[0], 1);

    for (int b = 0; b < 60; b++) begin
      p = ($urandom_range(0, 1) == 0) ? 3 : 40;
      for (int c = 0; c < 50; c++) begin
        msk = '0;
        for (int i = 0; i < W; i++) begin
          if ($urandom_range(0, p - 1) == 0) msk[i] = 1'b1;
        end
        raw_in = raw_in ^ msk;
        if ($urandom_range(0, 400) == 0) begin
          reset_n = 1'b0;
          hold(2);
          reset_n = 1'b1;
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
